// File: rtl/pipe_stage_if.sv
// Handshake/bus bundle for pipe_stage_reg: upstream-facing *_i fields and registered *_o copies.
// The master modport is the side that drives the stage; the slave modport is the stage itself.
interface pipe_stage_if #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_DATA = 2,
    parameter int unsigned PC_W     = 32,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned TNEW_W   = 2
);
    logic                       stall_i;
    logic                       flush_i;
    logic                       valid_i;
    logic [31:0]                ir_i;
    logic [PC_W-1:0]            pc_i;
    logic [NUM_DATA*DATA_W-1:0] data_i;
    logic [REG_AW-1:0]          a1_i;
    logic [REG_AW-1:0]          a2_i;
    logic [REG_AW-1:0]          wa_i;
    logic [TNEW_W-1:0]          tnew_i;

    logic                       valid_o;
    logic [31:0]                ir_o;
    logic [PC_W-1:0]            pc_o;
    logic [PC_W-1:0]            pc8_o;
    logic [NUM_DATA*DATA_W-1:0] data_o;
    logic [REG_AW-1:0]          a1_o;
    logic [REG_AW-1:0]          a2_o;
    logic [REG_AW-1:0]          wa_o;
    logic [TNEW_W-1:0]          tnew_o;

    modport master (
        output stall_i, flush_i, valid_i, ir_i, pc_i, data_i, a1_i, a2_i, wa_i, tnew_i,
        input  valid_o, ir_o, pc_o, pc8_o, data_o, a1_o, a2_o, wa_o, tnew_o
    );

    modport slave (
        input  stall_i, flush_i, valid_i, ir_i, pc_i, data_i, a1_i, a2_i, wa_i, tnew_i,
        output valid_o, ir_o, pc_o, pc8_o, data_o, a1_o, a2_o, wa_o, tnew_o
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall/flush, valid bit and in-place Tnew countdown.
// Define PIPE_PERF_CNT_EN to add the stall/bubble performance counters.
module pipe_stage_reg #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_DATA = 2,
    parameter int unsigned PC_W     = 32,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned TNEW_W   = 2
) (
    input  logic        clk,
    input  logic        reset,
    pipe_stage_if.slave bus
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] bubble_cnt_o
`endif
);

    localparam int unsigned DataTotW = NUM_DATA * DATA_W;

    logic                valid_q, valid_d;
    logic [31:0]         ir_q, ir_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [PC_W-1:0]     pc8_q, pc8_d;
    logic [DataTotW-1:0] data_q, data_d;
    logic [REG_AW-1:0]   a1_q, a1_d;
    logic [REG_AW-1:0]   a2_q, a2_d;
    logic [REG_AW-1:0]   wa_q, wa_d;
    logic [TNEW_W-1:0]   tnew_q, tnew_d;

    logic do_bubble;
    logic do_hold;

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

    // Flush wins over stall; an unstalled invalid input is just another bubble.
    always_comb begin
        do_bubble = bus.flush_i | (~bus.stall_i & ~bus.valid_i);
        do_hold   = ~bus.flush_i & bus.stall_i;
    end

    always_comb begin
        valid_d = valid_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        pc8_d   = pc8_q;
        data_d  = data_q;
        a1_d    = a1_q;
        a2_d    = a2_q;
        wa_d    = wa_q;
        tnew_d  = tnew_q;
        if (do_bubble) begin
            valid_d = 1'b0;
            ir_d    = '0;
            pc_d    = '0;
            pc8_d   = '0;
            data_d  = '0;
            a1_d    = '0;
            a2_d    = '0;
            wa_d    = '0;
            tnew_d  = '0;
        end else if (do_hold) begin
            tnew_d = sat_dec(tnew_q);
        end else begin
            valid_d = 1'b1;
            ir_d    = bus.ir_i;
            pc_d    = bus.pc_i;
            pc8_d   = bus.pc_i + PC_W'(8);
            data_d  = bus.data_i;
            a1_d    = bus.a1_i;
            a2_d    = bus.a2_i;
            wa_d    = bus.wa_i;
            // $0 never has a pending write, so it never stalls a consumer.
            tnew_d  = (bus.wa_i == '0) ? '0 : sat_dec(bus.tnew_i);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            ir_q    <= '0;
            pc_q    <= '0;
            pc8_q   <= '0;
            data_q  <= '0;
            a1_q    <= '0;
            a2_q    <= '0;
            wa_q    <= '0;
            tnew_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            pc8_q   <= pc8_d;
            data_q  <= data_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            wa_q    <= wa_d;
            tnew_q  <= tnew_d;
        end
    end

    assign bus.valid_o = valid_q;
    assign bus.ir_o    = ir_q;
    assign bus.pc_o    = pc_q;
    assign bus.pc8_o   = pc8_q;
    assign bus.data_o  = data_q;
    assign bus.a1_o    = a1_q;
    assign bus.a2_o    = a2_q;
    assign bus.wa_o    = wa_q;
    assign bus.tnew_o  = tnew_q;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = do_hold ? stall_cnt_q + 32'd1 : stall_cnt_q;
        bubble_cnt_d = do_bubble ? bubble_cnt_q + 32'd1 : bubble_cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table, reset corners, random vs model.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pipe_stage_if bus ();

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] bubble_cnt;
`endif

    pipe_stage_reg dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt_o  (stall_cnt),
        .bubble_cnt_o (bubble_cnt)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    // Expected architectural state of the stage.
    logic        m_valid;
    logic [31:0] m_ir, m_pc, m_pc8;
    logic [63:0] m_data;
    logic [4:0]  m_a1, m_a2, m_wa;
    int          m_tnew;
    logic [31:0] m_scnt, m_bcnt;

    typedef struct {
        logic        st, fl, va;
        logic [31:0] ir, pc;
        logic [63:0] data;
        logic [4:0]  wa;
        logic [1:0]  tn;
        logic        e_valid;
        logic [31:0] e_ir, e_pc8;
        logic [63:0] e_data;
        logic [1:0]  e_tnew;
    } vec_t;

    vec_t tbl[$];

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_ir = '0; m_pc = '0; m_pc8 = '0; m_data = '0;
        m_a1 = '0; m_a2 = '0; m_wa = '0; m_tnew = 0; m_scnt = '0; m_bcnt = '0;
    endtask

    task automatic model_edge();
        if (bus.flush_i || (!bus.stall_i && !bus.valid_i)) begin
            m_valid = 1'b0; m_ir = '0; m_pc = '0; m_pc8 = '0; m_data = '0;
            m_a1 = '0; m_a2 = '0; m_wa = '0; m_tnew = 0;
            m_bcnt = m_bcnt + 32'd1;
        end else if (bus.stall_i) begin
            m_tnew = (m_tnew > 0) ? m_tnew - 1 : 0;
            m_scnt = m_scnt + 32'd1;
        end else begin
            m_valid = 1'b1;
            m_ir = bus.ir_i;
            m_pc = bus.pc_i;
            m_pc8 = bus.pc_i + 32'd8;
            m_data = bus.data_i;
            m_a1 = bus.a1_i;
            m_a2 = bus.a2_i;
            m_wa = bus.wa_i;
            m_tnew = (bus.wa_i == 5'd0 || bus.tnew_i == 2'd0) ? 0 : int'(bus.tnew_i) - 1;
        end
    endtask

    task automatic check_all(input string tag);
        cmp({tag, ".valid"}, 64'(bus.valid_o), 64'(m_valid));
        cmp({tag, ".ir"},    64'(bus.ir_o),    64'(m_ir));
        cmp({tag, ".pc"},    64'(bus.pc_o),    64'(m_pc));
        cmp({tag, ".pc8"},   64'(bus.pc8_o),   64'(m_pc8));
        cmp({tag, ".data"},  bus.data_o,       m_data);
        cmp({tag, ".a1"},    64'(bus.a1_o),    64'(m_a1));
        cmp({tag, ".a2"},    64'(bus.a2_o),    64'(m_a2));
        cmp({tag, ".wa"},    64'(bus.wa_o),    64'(m_wa));
        cmp({tag, ".tnew"},  64'(bus.tnew_o),  64'(m_tnew));
`ifdef PIPE_PERF_CNT_EN
        cmp({tag, ".scnt"},  64'(stall_cnt),   64'(m_scnt));
        cmp({tag, ".bcnt"},  64'(bubble_cnt),  64'(m_bcnt));
`endif
    endtask

    task automatic drive(input logic st, input logic fl, input logic va, input logic [31:0] ir,
                         input logic [31:0] pc, input logic [63:0] data, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] wa, input logic [1:0] tn);
        bus.stall_i = st; bus.flush_i = fl; bus.valid_i = va; bus.ir_i = ir; bus.pc_i = pc;
        bus.data_i = data; bus.a1_i = a1; bus.a2_i = a2; bus.wa_i = wa; bus.tnew_i = tn;
    endtask

    task automatic step(input logic st, input logic fl, input logic va, input logic [31:0] ir,
                        input logic [31:0] pc, input logic [63:0] data, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [4:0] wa, input logic [1:0] tn);
        @(negedge clk);
        drive(st, fl, va, ir, pc, data, a1, a2, wa, tn);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rand_drive();
        logic [4:0] wa;
        wa = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
              $urandom, $urandom, {$urandom, $urandom}, 5'($urandom), 5'($urandom), wa,
              2'($urandom));
    endtask

    // Release reset at a negedge with a flush pending, so the first live edge is a known bubble.
    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b0, '0, '0, '0, '0, '0, '0, '0);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic add_vec(input logic st, input logic fl, input logic va, input logic [31:0] ir,
                           input logic [31:0] pc, input logic [63:0] data, input logic [4:0] wa,
                           input logic [1:0] tn, input logic ev, input logic [31:0] eir,
                           input logic [31:0] epc8, input logic [63:0] edata,
                           input logic [1:0] etn);
        vec_t v;
        v.st = st; v.fl = fl; v.va = va; v.ir = ir; v.pc = pc; v.data = data; v.wa = wa;
        v.tn = tn; v.e_valid = ev; v.e_ir = eir; v.e_pc8 = epc8; v.e_data = edata;
        v.e_tnew = etn;
        tbl.push_back(v);
    endtask

    initial begin
        add_vec(0, 0, 1, 32'h8C220004, 32'h3000, 64'hD0, 5'd2, 2'd2,
                1, 32'h8C220004, 32'h3008, 64'hD0, 2'd1);
        add_vec(0, 0, 1, 32'h11111111, 32'h4000, 64'hD1, 5'd5, 2'd3,
                1, 32'h11111111, 32'h4008, 64'hD1, 2'd2);
        add_vec(1, 0, 1, 32'hDEADBEEF, 32'h5000, 64'hEE, 5'd6, 2'd1,
                1, 32'h11111111, 32'h4008, 64'hD1, 2'd1);
        add_vec(1, 0, 1, 32'hDEADBEEF, 32'h5000, 64'hEE, 5'd6, 2'd1,
                1, 32'h11111111, 32'h4008, 64'hD1, 2'd0);
        add_vec(1, 0, 0, 32'hDEADBEEF, 32'h5000, 64'hEE, 5'd6, 2'd1,
                1, 32'h11111111, 32'h4008, 64'hD1, 2'd0);
        add_vec(0, 0, 1, 32'h22222222, 32'hFFFFFFFC, 64'hD2, 5'd0, 2'd3,
                1, 32'h22222222, 32'h00000004, 64'hD2, 2'd0);
        add_vec(0, 0, 1, 32'h33333333, 32'h100, 64'hD3, 5'd4, 2'd0,
                1, 32'h33333333, 32'h108, 64'hD3, 2'd0);
        add_vec(0, 0, 1, 32'h44444444, 32'h200, 64'hD4, 5'd7, 2'd1,
                1, 32'h44444444, 32'h208, 64'hD4, 2'd0);
        add_vec(0, 0, 1, 32'h55555555, 32'h300, 64'hD5, 5'd7, 2'd3,
                1, 32'h55555555, 32'h308, 64'hD5, 2'd2);
        add_vec(1, 1, 1, 32'h66666666, 32'h400, 64'hD6, 5'd3, 2'd2,
                0, 32'h0, 32'h0, 64'h0, 2'd0);
        add_vec(0, 0, 1, 32'h77777777, 32'h500, 64'hD7, 5'd3, 2'd2,
                1, 32'h77777777, 32'h508, 64'hD7, 2'd1);
        add_vec(0, 0, 0, 32'h88888888, 32'h600, 64'hD8, 5'd3, 2'd2,
                0, 32'h0, 32'h0, 64'h0, 2'd0);
        add_vec(0, 1, 1, 32'h99999999, 32'h700, 64'hD9, 5'd3, 2'd2,
                0, 32'h0, 32'h0, 64'h0, 2'd0);

        model_reset();
        drive(1'b0, 1'b0, 1'b1, '0, '0, '0, '0, '0, '0, '0);

        // Held in reset with live input traffic: nothing may leak through.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rand_drive();
            @(posedge clk);
            #1;
            cmp("rst.valid", 64'(bus.valid_o), 64'd0);
            cmp("rst.ir",    64'(bus.ir_o),    64'd0);
            cmp("rst.pc8",   64'(bus.pc8_o),   64'd0);
            cmp("rst.data",  bus.data_o,       64'd0);
            cmp("rst.tnew",  64'(bus.tnew_o),  64'd0);
        end
        release_reset();
        check_all("rel");

        foreach (tbl[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            step(tbl[i].st, tbl[i].fl, tbl[i].va, tbl[i].ir, tbl[i].pc, tbl[i].data,
                 5'd1, 5'd2, tbl[i].wa, tbl[i].tn);
            cmp({tag, ".valid"}, 64'(bus.valid_o), 64'(tbl[i].e_valid));
            cmp({tag, ".ir"},    64'(bus.ir_o),    64'(tbl[i].e_ir));
            cmp({tag, ".pc8"},   64'(bus.pc8_o),   64'(tbl[i].e_pc8));
            cmp({tag, ".data"},  bus.data_o,       tbl[i].e_data);
            cmp({tag, ".tnew"},  64'(bus.tnew_o),  64'(tbl[i].e_tnew));
`ifdef PIPE_PERF_CNT_EN
            cmp({tag, ".scnt"},  64'(stall_cnt),   64'(m_scnt));
            cmp({tag, ".bcnt"},  64'(bubble_cnt),  64'(m_bcnt));
`endif
        end

        // Async reset pulse while a valid instruction is held by stall.
        step(0, 0, 1, 32'hABCD0123, 32'h8000, 64'hCAFE, 5'd3, 5'd4, 5'd9, 2'd3);
        step(1, 0, 1, 32'h0, 32'h0, 64'h0, 5'd0, 5'd0, 5'd0, 2'd0);
        check_all("hold");
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("async");
        release_reset();
        check_all("rel2");

`ifdef PIPE_PERF_CNT_EN
        @(negedge clk);
        force dut.stall_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.stall_cnt_q;
        m_scnt = 32'hFFFFFFFF;
        step(1, 0, 1, 32'h0, 32'h0, 64'h0, 5'd0, 5'd0, 5'd0, 2'd0);
        cmp("wrap.scnt", 64'(stall_cnt), 64'd0);
`endif

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rand_drive();
            @(posedge clk);
            model_edge();
            #1;
            check_all($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
